// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder sequencer.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder; the one arithmetic resource the sequencer reuses each cycle.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_seq.sv
// Adds two WIDTH-bit words LSB first through one shared full-adder cell,
// one bit per clock, with valid/ready handshakes on both sides.
module serial_adder_seq
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             fa_s;
  logic             fa_co;

  full_adder_cell u_cell (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign cnt_last  = (cnt == CNT_W'(WIDTH - 1));
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_RUN) || (state == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid && !flush) state_nxt = S_RUN;
      S_RUN: begin
        if (flush)         state_nxt = S_IDLE;
        else if (cnt_last) state_nxt = S_DONE;
      end
      // No accept is allowed in the delivery cycle; IDLE must be visited first.
      S_DONE:  if (flush || out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && in_valid && !flush) begin
        a_sh   <= a;
        b_sh   <= b;
        carry  <= cin;
        cnt    <= '0;
        sum_sh <= '0;
      end else if (state == S_RUN && !flush) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
        carry  <= fa_co;
        cnt    <= cnt + CNT_W'(1);
        // The visible result only changes when a word completes.
        if (cnt_last) begin
          sum_q  <= {fa_s, sum_sh[WIDTH-1:1]};
          cout_q <= fa_co;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Randomized bench for serial_adder_seq against an A+B+cin reference.
module tb_serial_adder_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int           n_chk  = 0;
  int           n_pass = 0;
  logic [W-1:0] last_sum;

  always #5 clk = ~clk;

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; stall = cycles of out_ready=0 after out_valid rises.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic oc, input int stall);
    logic [W:0] exp;
    int         n;
    exp = {1'b0, oa} + {1'b0, ob} + (W+1)'(oc);
    check("in_ready_idle", 32'(in_ready), 1);
    a = oa; b = ob; cin = oc; in_valid = 1'b1;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    n = 0;
    while (!out_valid && n < W + 8) begin
      check("in_ready_run", 32'(in_ready), 0);
      tick();
      n++;
    end
    check("latency", n, W);
    check("sum", 32'(sum), 32'(exp[W-1:0]));
    check("cout", 32'(cout), 32'(exp[W]));
    check("busy_done", 32'(busy), 1);
    check("in_ready_done", 32'(in_ready), 0);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      tick();
      check("hold_valid", 32'(out_valid), 1);
      check("hold_sum", 32'(sum), 32'(exp[W-1:0]));
      check("hold_cout", 32'(cout), 32'(exp[W]));
      check("hold_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("valid_drop", 32'(out_valid), 0);
    check("in_ready_back", 32'(in_ready), 1);
    check("sum_kept", 32'(sum), 32'(exp[W-1:0]));
    last_sum = exp[W-1:0];
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; last_sum = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_cout", 32'(cout), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 1);

    do_op(8'h5A, 8'h3C, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 0);
    do_op(8'hFF, 8'hFF, 1'b1, 0);
    do_op(8'hC3, 8'h7E, 1'b1, 5);

    // Flush in the middle of a word
    a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_out_valid", 32'(out_valid), 0);
    check("flush_in_ready", 32'(in_ready), 1);
    check("flush_busy", 32'(busy), 0);
    check("flush_sum_kept", 32'(sum), 32'(last_sum));
    n_chk++;
    begin
      bit rose = 1'b0;
      for (int i = 0; i < W + 2; i++) begin
        tick();
        if (out_valid) rose = 1'b1;
      end
      if (!rose) n_pass++;
      else $display("FAIL flush_no_valid: got 1 expected 0");
    end
    do_op(8'h01, 8'h02, 1'b1, 0);

    // Flush in IDLE blocks an accept
    flush = 1'b1; in_valid = 1'b1; a = 8'h55; b = 8'h66;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("idle_flush_in_ready", 32'(in_ready), 1);
    check("idle_flush_busy", 32'(busy), 0);

    // Reset mid-RUN
    a = 8'hAB; b = 8'hCD; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstrun_out_valid", 32'(out_valid), 0);
    check("rstrun_sum", 32'(sum), 0);
    check("rstrun_cout", 32'(cout), 0);
    check("rstrun_in_ready", 32'(in_ready), 1);

    // Reset while holding a result in DONE
    out_ready = 1'b0;
    a = 8'hF1; b = 8'h22; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) tick();
    check("done_reached", 32'(out_valid), 1);
    check("done_sum", 32'(sum), 32'(8'h13));
    check("done_cout", 32'(cout), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    check("rstdone_out_valid", 32'(out_valid), 0);
    check("rstdone_sum", 32'(sum), 0);
    check("rstdone_cout", 32'(cout), 0);
    check("rstdone_in_ready", 32'(in_ready), 1);

    // Reset wins over flush and in_valid
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; a = 8'h0F; b = 8'hF0;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("rstall_in_ready", 32'(in_ready), 1);
    check("rstall_busy", 32'(busy), 0);
    tick();
    check("rstall_no_accept", 32'(busy), 0);

    for (int i = 0; i < 300; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
Sequencer that time-multiplexes one combinational full-adder cell to add two WIDTH-bit operands bit-serially, LSB first, one bit per clock.
- Operands and results move over valid/ready handshakes.
- Used inside the full-adder tile to add words wider than the single cell.
- The owning top level drives the operand registers from ui_in/uio_in and drives uo_out from the result.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous abort of the operation in flight
in_valid  input  1  operands a, b, cin are presented
in_ready  output  1  block can accept operands (IDLE only)
a  input  WIDTH  addend A
b  input  WIDTH  addend B
cin  input  1  carry-in of the word
out_valid  output  1  sum/cout are valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  A+B+cin, low WIDTH bits
cout  output  1  carry-out of the word
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. At rst=1 on a clock edge:
  - state=IDLE, bit counter=0, carry reg=0, operand and result shift registers=0.
  - Outputs after that edge: out_valid=0, sum=0, cout=0, busy=0, in_ready=1.
- Priority: rst > flush > handshakes.
- State machine (states IDLE, RUN, DONE):
  - IDLE:
    - in_ready=1.
    - Accept on the edge where in_valid&&in_ready&&!flush.
    - On accept: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum_sh<=0, state->RUN.
    - Outputs are not changed while in IDLE: sum/cout keep the last delivered result.
  - RUN, each cycle:
    - Cell inputs: a_sh[0], b_sh[0], carry.
    - sum_sh <= {s, sum_sh[WIDTH-1:1]}; carry <= c_out.
    - a_sh, b_sh shift right by 1; cnt <= cnt+1.
    - On the cycle where cnt==WIDTH-1, the edge loads the final bit and sets state->DONE.
    - RUN therefore lasts exactly WIDTH cycles.
  - DONE:
    - out_valid=1; sum=sum_sh; cout=carry.
    - All values are held stable while out_ready=0, with no limit on how long.
    - On the edge where out_valid&&out_ready: state->IDLE.
- Latency: accept edge at k; out_valid is first high after edge k+WIDTH. The earliest next accept is at edge k+WIDTH+2 (one DONE cycle, then IDLE).
- in_ready is combinational from state only; it is low in RUN and DONE. in_valid is ignored there and operands are not sampled.
- There is no accept in the same cycle as result delivery. The DONE->IDLE transition must happen first (deliberate, for simple timing).
- flush=1:
  - In RUN or DONE: state->IDLE next edge; out_valid=0; partial result is discarded; registered sum/cout are left unchanged.
  - In IDLE: no effect, and it blocks an accept in the same cycle.
- rst mid-RUN or mid-DONE: identical to power-on reset; no output is produced.
- Arithmetic: the result is exact modulo 2^WIDTH, with cout = bit WIDTH of A+B+cin.
- Counter width: $clog2(WIDTH). The counter never wraps because it is reset on accept.
- The state register must be one-hot or a 2-bit encoding. An illegal encoding returns to IDLE on the next edge.

Decomposition:
- Package serial_adder_pkg holds:
  - typedef enum logic[1:0] state_t {S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10}
  - localparam MAX_WIDTH=32
- One combinational sub-module, full_adder_cell:
  - Inputs a, b, ci; outputs s, co.
  - s = a^b^ci; co = a&b | ci&(a^b).
  - Instantiated exactly once; this is the shared resource being sequenced.

Test Plan:
- WIDTH=8: a=0x5A, b=0x3C, cin=0, out_ready=1 -> in_ready low for 9 cycles; out_valid high exactly 8 cycles after accept edge with sum=0x96, cout=0; in_ready=1 one cycle later.
- Carry ripple: 0xFF+0x01, cin=0 -> sum=0x00, cout=1. Also 0xFF+0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands driven -> sum/cout/out_valid stable; in_ready=0; new operands ignored; result delivered on the first out_ready=1 edge.
- Flush: flush at RUN cycle 3 of 0x12+0x34 -> IDLE next edge, out_valid never rises. A following 0x01+0x02, cin=1 -> sum=0x04, cout=0.
- Reset: rst mid-RUN and in DONE -> next edge out_valid=0, sum=0, cout=0, in_ready=1. rst together with flush and in_valid -> reset result only.
- WIDTH=4 build: random 500 operand pairs checked against A+B+cin with a scoreboard -> all match; latency always 4 cycles to out_valid.
